// File: rtl/pool2_sm8_if.sv
// rtl/pool2_sm8_if.sv - conv-result stream in, pooled sign-magnitude pixels out.
interface pool2_sm8_if #(
  parameter int DW = 32
);
  logic signed [DW-1:0] din;
  logic                 ivalid;
  logic [7:0]           dout;
  logic                 ovalid;
  logic                 done;

  modport master (output din, ivalid, input dout, ovalid, done);
  modport slave  (input din, ivalid, output dout, ovalid, done);
endinterface

// File: rtl/pool2_sm8.sv
// rtl/pool2_sm8.sv - 2x2 stride-2 max pool of a WxW conv map, re-encoded to 8-bit sign-magnitude.
module pool2_sm8 #(
  parameter int W  = 24,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  pool2_sm8_if.slave    bus
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);
  localparam logic signed [DW-1:0] POS_SAT = 127;
  localparam logic signed [DW-1:0] NEG_SAT = -127;

  logic [CW-1:0]        col_q, row_q, col_d, row_d;
  logic signed [DW-1:0] pair_q;
  logic signed [DW-1:0] linebuf_q [W/2];
  logic [7:0]           dout_q;
  logic                 ovalid_q, done_q, last_q;

  logic [CW-2:0]        idx;
  logic signed [DW-1:0] hmax, vmax, lb_rd;
  logic                 frame_end;

  // Saturating sign-magnitude; the most negative input is caught before negation.
  function automatic logic [7:0] enc(input logic signed [DW-1:0] v);
    logic signed [DW-1:0] neg;
    neg = '0;
    if (v >= 0) begin
      enc = (v > POS_SAT) ? 8'h7F : {1'b0, v[6:0]};
    end else if (v < NEG_SAT) begin
      enc = 8'hFF;
    end else begin
      neg = -v;
      enc = {1'b1, neg[6:0]};
    end
  endfunction

  always_comb begin
    idx       = col_q[CW-1:1];
    lb_rd     = linebuf_q[idx];
    hmax      = (pair_q > bus.din) ? pair_q : bus.din;
    vmax      = (lb_rd > hmax) ? lb_rd : hmax;
    frame_end = (col_q == LAST) && (row_q == LAST);
    col_d     = col_q;
    row_d     = row_q;
    if (bus.ivalid) begin
      if (col_q == LAST) begin
        col_d = '0;
        row_d = (row_q == LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Line buffer is never reset: each entry is written on an even row before its odd-row read.
  always_ff @(posedge clk) begin
    if (rst || !start) begin
      col_q    <= '0;
      row_q    <= '0;
      pair_q   <= '0;
      dout_q   <= 8'h00;
      ovalid_q <= 1'b0;
      done_q   <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      col_q    <= col_d;
      row_q    <= row_d;
      ovalid_q <= 1'b0;
      done_q   <= last_q;
      last_q   <= 1'b0;
      if (bus.ivalid) begin
        if (!col_q[0]) begin
          pair_q <= bus.din;
        end else if (!row_q[0]) begin
          linebuf_q[idx] <= hmax;
        end else begin
          dout_q   <= enc(vmax);
          ovalid_q <= 1'b1;
          last_q   <= frame_end;
        end
      end
    end
  end

  assign bus.dout   = dout_q;
  assign bus.ovalid = ovalid_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_pool2_sm8.sv
// tb/tb_pool2_sm8.sv - scoreboard bench for pool2_sm8 at W=24 and W=8.
module tb_pool2_sm8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start24, start8;
  pool2_sm8_if #(.DW(32)) if24();
  pool2_sm8_if #(.DW(32)) if8();

  pool2_sm8 #(.W(24), .DW(32)) u24 (.clk(clk), .rst(rst), .start(start24), .bus(if24.slave));
  pool2_sm8 #(.W(8),  .DW(32)) u8  (.clk(clk), .rst(rst), .start(start8),  .bus(if8.slave));

  typedef struct {
    logic [7:0] d;
    int         cyc;
  } exp_t;

  exp_t q24[$];
  exp_t q8[$];
  int   dq24[$];
  int   dq8[$];
  exp_t e24, e8;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, fails = 0;
  int ov24_n = 0, ov8_n = 0, dn24_n = 0, dn8_n = 0;

  int          fr [0:23][0:23];
  logic [8:0]  ovr [0:143];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (if24.ovalid === 1'b1) begin
      ov24_n++;
      if (q24.size() == 0) chk("ovalid24_unexpected", 1, 0);
      else begin
        e24 = q24.pop_front();
        chk("dout24", {24'h0, if24.dout}, {24'h0, e24.d});
        chk("latency24", cyc, e24.cyc);
      end
    end
    if (if24.done === 1'b1) begin
      dn24_n++;
      if (dq24.size() == 0) chk("done24_unexpected", 1, 0);
      else chk("done24_cycle", cyc, dq24.pop_front());
    end
    if (if24.ovalid === 1'b1 && if24.done === 1'b1) chk("ovalid_done24_overlap", 1, 0);
  end

  always @(negedge clk) begin
    if (if8.ovalid === 1'b1) begin
      ov8_n++;
      if (q8.size() == 0) chk("ovalid8_unexpected", 1, 0);
      else begin
        e8 = q8.pop_front();
        chk("dout8", {24'h0, if8.dout}, {24'h0, e8.d});
        chk("latency8", cyc, e8.cyc);
      end
    end
    if (if8.done === 1'b1) begin
      dn8_n++;
      if (dq8.size() == 0) chk("done8_unexpected", 1, 0);
      else chk("done8_cycle", cyc, dq8.pop_front());
    end
    if (if8.ovalid === 1'b1 && if8.done === 1'b1) chk("ovalid_done8_overlap", 1, 0);
  end

  function automatic logic [7:0] enc(input longint v);
    longint m;
    m = (v < 0) ? -v : v;
    if (m > 127) m = 127;
    return (v < 0) ? {1'b1, m[6:0]} : {1'b0, m[6:0]};
  endfunction

  function automatic longint mx(input longint a, input longint b);
    return (a > b) ? a : b;
  endfunction

  task automatic put(input int w, input logic signed [31:0] v, input logic vld);
    @(posedge clk);
    #1;
    if (w == 24) begin if24.din = v; if24.ivalid = vld; end
    else begin if8.din = v; if8.ivalid = vld; end
  endtask

  task automatic run_frame(input int w, input int nsamp, input bit gapped);
    int   k;
    int   pix;
    exp_t e;
    k = 0;
    for (int r = 0; r < w; r++) begin
      for (int c = 0; c < w; c++) begin
        if (k < nsamp) begin
          put(w, fr[r][c], 1'b1);
          if ((r % 2 == 1) && (c % 2 == 1)) begin
            pix   = (r / 2) * (w / 2) + c / 2;
            e.cyc = cyc + 1;
            e.d   = ovr[pix][8] ? ovr[pix][7:0]
                  : enc(mx(mx(fr[r-1][c-1], fr[r-1][c]), mx(fr[r][c-1], fr[r][c])));
            if (w == 24) q24.push_back(e); else q8.push_back(e);
          end
          if (r == w - 1 && c == w - 1) begin
            if (w == 24) dq24.push_back(cyc + 2); else dq8.push_back(cyc + 2);
          end
          k++;
          if (gapped && c == w - 1) repeat (4) put(w, $urandom, 1'b0);
        end
      end
    end
  endtask

  task automatic idle(input int w, input int n);
    repeat (n) put(w, 0, 1'b0);
  endtask

  task automatic fill_rand(input int w, input int lo, input int hi);
    for (int r = 0; r < w; r++)
      for (int c = 0; c < w; c++)
        fr[r][c] = (hi > lo) ? lo + int'($urandom_range(hi - lo)) : int'($urandom);
  endtask

  int ov0, dn0;

  initial begin
    rst = 1'b1; start24 = 1'b0; start8 = 1'b0;
    if24.din = '0; if24.ivalid = 1'b0;
    if8.din  = '0; if8.ivalid  = 1'b0;
    for (int i = 0; i < 144; i++) ovr[i] = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_dout24", {24'h0, if24.dout}, 0);
    chk("reset_ovalid24", {31'h0, if24.ovalid}, 0);
    chk("reset_done24", {31'h0, if24.done}, 0);
    chk("reset_dout8", {24'h0, if8.dout}, 0);
    chk("reset_ovalid8", {31'h0, if8.ovalid}, 0);
    chk("reset_done8", {31'h0, if8.done}, 0);
    rst = 1'b0;

    // Ramp W=24
    for (int r = 0; r < 24; r++) for (int c = 0; c < 24; c++) fr[r][c] = r * 24 + c;
    ovr[0] = {1'b1, 8'h19};
    start24 = 1'b1;
    ov0 = ov24_n; dn0 = dn24_n;
    run_frame(24, 576, 1'b0);
    idle(24, 4);
    chk("ramp_pulses", ov24_n - ov0, 144);
    chk("ramp_done", dn24_n - dn0, 1);
    ovr[0] = '0;

    // Negative / saturating W=8
    for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) fr[r][c] = 0;
    fr[0][0] = -5;  fr[0][1] = -9;  fr[1][0] = -7;   fr[1][1] = -6;
    fr[0][2] = -3;  fr[0][3] = -2;  fr[1][2] = 1000; fr[1][3] = -1;
    fr[0][4] = 32'h8000_0000; fr[0][5] = 32'h8000_0000;
    fr[1][4] = 32'h8000_0000; fr[1][5] = 32'h8000_0000;
    ovr[0] = {1'b1, 8'h85}; ovr[1] = {1'b1, 8'h7F};
    ovr[2] = {1'b1, 8'hFF}; ovr[3] = {1'b1, 8'h00};
    start8 = 1'b1;
    ov0 = ov8_n; dn0 = dn8_n;
    run_frame(8, 64, 1'b0);
    idle(8, 4);
    chk("neg_pulses", ov8_n - ov0, 16);
    chk("neg_done", dn8_n - dn0, 1);
    for (int i = 0; i < 4; i++) ovr[i] = '0;

    // Gapped input W=8
    fill_rand(8, 0, 0);
    ov0 = ov8_n; dn0 = dn8_n;
    run_frame(8, 64, 1'b1);
    idle(8, 4);
    chk("gap_pulses", ov8_n - ov0, 16);
    chk("gap_done", dn8_n - dn0, 1);

    // Back-to-back frames W=8; first frame large to expose stale line-buffer reads
    ov0 = ov8_n; dn0 = dn8_n;
    fill_rand(8, 10000, 20000);
    run_frame(8, 64, 1'b0);
    fill_rand(8, -50, 50);
    run_frame(8, 64, 1'b0);
    idle(8, 4);
    chk("b2b_pulses", ov8_n - ov0, 32);
    chk("b2b_done", dn8_n - dn0, 2);

    // Mid-frame abort W=24
    ov0 = ov24_n; dn0 = dn24_n;
    fill_rand(24, 0, 0);
    run_frame(24, 40, 1'b0);
    put(24, 0, 1'b0);
    start24 = 1'b0;
    put(24, 0, 1'b0);
    chk("abort_ovalid_low", {31'h0, if24.ovalid}, 0);
    idle(24, 2);
    start24 = 1'b1;
    fill_rand(24, -300, 300);
    run_frame(24, 576, 1'b0);
    idle(24, 4);
    chk("abort_pulses", ov24_n - ov0, 152);
    chk("abort_done", dn24_n - dn0, 1);

    // Reset at row 5, col 13
    fill_rand(24, -200, 200);
    run_frame(24, 5 * 24 + 13, 1'b0);
    put(24, 0, 1'b0);
    rst = 1'b1;
    put(24, 0, 1'b0);
    rst = 1'b0;
    chk("rst_mid_dout", {24'h0, if24.dout}, 0);
    chk("rst_mid_ovalid", {31'h0, if24.ovalid}, 0);
    chk("rst_mid_done", {31'h0, if24.done}, 0);
    ov0 = ov24_n; dn0 = dn24_n;
    fill_rand(24, 0, 0);
    run_frame(24, 576, 1'b0);
    idle(24, 4);
    chk("post_rst_pulses", ov24_n - ov0, 144);
    chk("post_rst_done", dn24_n - dn0, 1);

    chk("q24_empty", q24.size() + dq24.size(), 0);
    chk("q8_empty", q8.size() + dq8.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/pool2_sm8.md
Name: pool2_sm8

Overview:
- Downstream of the 5x5 binary-weight convolution stage. Consumes its 32-bit signed results as they arrive under the conv output-valid strobe.
- Performs 2x2 stride-2 max pooling on each feature map, e.g. 24x24 → 12x12 for layer 1.
- Re-encodes each pooled value into the 8-bit sign-magnitude pixel format used by the sliding-window/conv input.
- Results feed the next layer's line buffer.

Parameters:
- W, 24, conv output width and height in valid samples (24 for layer 1, 8 for layer 2); must be even, ≥2.
- DW, 32, input data width (two's complement).

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  frame enable; low clears counters and pipeline state, same framing as the conv start.
- din  input  DW  signed conv result.
- ivalid  input  1  din qualifier; only these samples are counted, non-valid cycles (row gaps) are ignored.
- dout  output  8  pooled pixel, sign-magnitude: bit7 = sign, [6:0] = magnitude.
- ovalid  output  1  dout qualifier, one-cycle pulse per pooled pixel.
- done  output  1  one-cycle pulse after the last pooled pixel of a frame.

Behaviour:
- Reset (rst=1 at clk edge) or start=0: col=0, row=0, pair register cleared, dout=8'h00, ovalid=0, done=0. Line-buffer contents are don't-care; every entry is written before it is read.
- Counters advance only when ivalid=1:
  - col counts 0..W-1, then wraps to 0 and increments row.
  - row counts 0..W-1, then wraps to 0 (next frame).
- Horizontal pairing:
  - even col: din → pair_reg.
  - odd col: hmax = max(pair_reg, din), signed compare.
- Row pairing:
  - even row, odd col: hmax → linebuf[col>>1]. linebuf has W/2 entries, DW bits wide.
  - odd row, odd col: vmax = max(linebuf[col>>1], hmax), registered.
- Output timing:
  - ovalid=1 exactly one cycle after the accepted odd-row/odd-col sample, with dout carrying that vmax.
  - Latency is 1 clk from the last contributing sample.
  - Outputs per frame: (W/2)^2, i.e. 144 for W=24, 16 for W=8.
- Encoding of vmax to dout:
  - vmax ≥ 0 → {1'b0, min(vmax,127)[6:0]}.
  - vmax < 0 → {1'b1, min(−vmax,127)[6:0]}.
  - vmax = −2^(DW−1) → 8'hFF; the negation must not overflow.
  - Zero → 8'h00. Negative zero is never produced.
- Ties: equal values select either operand; the result is identical.
- done:
  - Pulses 1 cycle, on the cycle after the ovalid of pixel (W/2−1, W/2−1), i.e. when the frame-final row/col wrap is consumed.
  - done and ovalid are never high together.
- Frame boundary: a new frame may begin on the very next ivalid after the wrap. No dead cycles are required, and pair/row state restarts cleanly.
- start falling mid-frame: partial frame discarded, no done, ovalid forced 0 the next cycle; start rising resumes from col=0, row=0.
- rst has priority over start and ivalid.
- ivalid held low arbitrarily long between samples: state is held, output timing stays relative to the accepted samples.
- No back-pressure: downstream must accept every ovalid pulse.

Test Plan:
- Ramp, W=24: din = row*24+col, ivalid continuous → 144 pulses; pixel (r,c) magnitude = min((2r+1)*24+2c+1, 127). First dout = 8'h19 (25); done 1 cycle after the 144th pulse.
- Negative and saturating values, W=8: block values {−5,−9,−7,−6} → dout 8'h85; block {−3,−2,1000,−1} → 8'h7F; block all −2^31 → 8'hFF; block all 0 → 8'h00.
- Gapped input, W=8: ivalid asserted on 8 of every 12 cycles (conv row gap pattern), random din → outputs match a golden model; 16 ovalid pulses; each pulse 1 cycle after its 4th contributing sample.
- Back-to-back frames, W=8: two frames with no idle cycles → 32 pulses and 2 done pulses. Second-frame pixel (0,0) depends only on second-frame data (first-frame linebuf values chosen larger to expose stale reads).
- Mid-frame abort: drop start after 40 samples of a W=24 frame, reassert 3 cycles later with a fresh frame → no done for the aborted frame; exactly 144 correct outputs for the new frame.
- Reset mid-operation: assert rst for 1 cycle at row 5, col 13 → next cycle dout=8'h00, ovalid=0, done=0; a subsequent full frame produces correct results.
